// File: rtl/chop_if.sv
// DTI stream interface: payload word plus valid/ready handshake and an
// end-of-transaction sideband bit that travels with each element.
interface dti_s_if #(
    parameter int W = 1
) ();
    logic [W-1:0] data;
    logic         dvalid;
    logic         dready;
    logic         eot;

    modport producer (output data, output dvalid, output eot, input dready);
    modport consumer (input data, input dvalid, input eot, output dready);
endinterface

// File: rtl/chop.sv
// chop: adds one innermost eot level to a DTI queue stream by grouping
// consecutive elements into chunks of SIZE elements.
//
// Input word:  {eot[DIN_LVL-1:0], data[TDIN-1:0]}
// Output word: {eot[DIN_LVL:0],   data[TDIN-1:0]}
//   new eot[0] = chunk end | input eot[0]; upper eot bits are the input eot bits.
//
// Optional feature macro: CHOP_OUT_REG_EN
//   defined   -> one-entry registered output stage (latency 1, full throughput)
//   undefined -> purely combinational datapath (latency 0)
module chop #(
    parameter int TDIN    = 17,
    parameter int DIN_LVL = 1,
    parameter int SIZE    = 4
) (
    input logic       clk,
    input logic       rst,
    dti_s_if.consumer din,
    dti_s_if.producer dout
);

    localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int OW = TDIN + DIN_LVL + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(SIZE - 1);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          chunk_end_s;
    logic          in_eot0_s;
    logic          eot0_s;
    logic          in_xfer_s;
    logic [OW-1:0] out_word_s;

    assign chunk_end_s = (cnt_r == LAST_CNT);
    assign eot0_s      = chunk_end_s | in_eot0_s;
    assign in_xfer_s   = din.dvalid & din.dready;

    // Field mapping: with no eot levels on the input the chunk end is the only eot.
    generate
        if (DIN_LVL > 0) begin : g_lvl
            assign in_eot0_s  = din.data[TDIN];
            assign out_word_s = {din.data[TDIN+DIN_LVL-1:TDIN], eot0_s, din.data[TDIN-1:0]};
        end else begin : g_flat
            assign in_eot0_s  = 1'b0;
            assign out_word_s = {eot0_s, din.data[TDIN-1:0]};
        end
    endgenerate

    // Chunk position: restart after any closed chunk (full or cut short by input eot).
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (in_xfer_s) begin
            if (eot0_s) begin
                cnt_nxt_s = '0;
            end else begin
                cnt_nxt_s = cnt_r + CW'(1);
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Chunk position register; reset abandons any partial chunk.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

`ifdef CHOP_OUT_REG_EN
    logic          out_vld_r;
    logic [OW-1:0] out_data_r;
    logic          out_eot_r;

    // Accept whenever the stage is empty or is being drained this cycle.
    assign din.dready  = ~out_vld_r | dout.dready;
    assign dout.dvalid = out_vld_r;
    assign dout.data   = out_data_r;
    assign dout.eot    = out_eot_r;

    // Output valid: set on load, cleared by a drain with no new load.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_r <= 1'b0;
        end else if (in_xfer_s) begin
            out_vld_r <= 1'b1;
        end else if (dout.dready) begin
            out_vld_r <= 1'b0;
        end else begin
            out_vld_r <= out_vld_r;
        end
    end

    // Output payload: loads only on an input transfer, so it holds under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_r <= '0;
            out_eot_r  <= 1'b0;
        end else if (in_xfer_s) begin
            out_data_r <= out_word_s;
            out_eot_r  <= din.eot;
        end else begin
            out_data_r <= out_data_r;
            out_eot_r  <= out_eot_r;
        end
    end
`else
    // Combinational pass-through: handshake and sideband flow straight through.
    assign din.dready  = dout.dready;
    assign dout.dvalid = din.dvalid;
    assign dout.data   = out_word_s;
    assign dout.eot    = din.eot;
`endif

endmodule

// File: tb/tb_chop.sv
// Directed testbench for chop: three instances cover SIZE=4/DIN_LVL=1,
// SIZE=3/DIN_LVL=1 under backpressure, and SIZE=1/DIN_LVL=0.
module tb_chop;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

`ifdef CHOP_OUT_REG_EN
    localparam int EXP_TP = 99;
`else
    localparam int EXP_TP = 100;
`endif

    dti_s_if #(.W(18)) a_in ();
    dti_s_if #(.W(19)) a_out ();
    dti_s_if #(.W(18)) b_in ();
    dti_s_if #(.W(19)) b_out ();
    dti_s_if #(.W(17)) c_in ();
    dti_s_if #(.W(18)) c_out ();

    chop #(.TDIN(17), .DIN_LVL(1), .SIZE(4)) dut_a (.clk(clk), .rst(rst), .din(a_in), .dout(a_out));
    chop #(.TDIN(17), .DIN_LVL(1), .SIZE(3)) dut_b (.clk(clk), .rst(rst), .din(b_in), .dout(b_out));
    chop #(.TDIN(17), .DIN_LVL(0), .SIZE(1)) dut_c (.clk(clk), .rst(rst), .din(c_in), .dout(c_out));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Collected output elements: {sideband eot, dout.data}
    logic [19:0] qa[$];
    logic [19:0] qb[$];
    logic [18:0] qc[$];
    logic [19:0] ref_q[$];
    int          b_unstable;
    logic        b_hold;
    logic [19:0] b_prev;

    // Output monitors sample at the falling edge, between driving and capture.
    always @(negedge clk) begin
        if (!rst && a_out.dvalid && a_out.dready) qa.push_back({a_out.eot, a_out.data});
        if (!rst && b_out.dvalid && b_out.dready) qb.push_back({b_out.eot, b_out.data});
        if (!rst && c_out.dvalid && c_out.dready) qc.push_back({c_out.eot, c_out.data});
    end

    // Stall stability watch on the backpressured instance.
    always @(negedge clk) begin
        if (!rst && b_hold && ({b_out.eot, b_out.data} !== b_prev)) b_unstable <= b_unstable + 1;
        b_hold <= !rst && b_out.dvalid && !b_out.dready;
        b_prev <= {b_out.eot, b_out.data};
    end

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_a(input logic [16:0] d, input logic e);
        logic acc;
        acc = 1'b0;
        a_in.data = {e, d};
        a_in.eot = e;
        a_in.dvalid = 1'b1;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = a_in.dready;
            @(posedge clk);
            #1;
        end
        a_in.dvalid = 1'b0;
        if (!acc) begin
            n_tests++; n_fail++;
            $display("FAIL send_a_timeout data=%0h not accepted within 50 cycles", d);
        end
    endtask

    task automatic send_b(input logic [16:0] d, input logic e, input bit bp);
        logic acc;
        acc = 1'b0;
        b_in.data = {e, d};
        b_in.eot = e;
        b_in.dvalid = 1'b1;
        for (int k = 0; k < 200 && !acc; k++) begin
            b_out.dready = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
            @(negedge clk);
            acc = b_in.dready;
            @(posedge clk);
            #1;
        end
        b_in.dvalid = 1'b0;
        if (!acc) begin
            n_tests++; n_fail++;
            $display("FAIL send_b_timeout data=%0h not accepted within 200 cycles", d);
        end
    endtask

    task automatic send_c(input logic [16:0] d);
        logic acc;
        acc = 1'b0;
        c_in.data = d;
        c_in.eot = 1'b0;
        c_in.dvalid = 1'b1;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = c_in.dready;
            @(posedge clk);
            #1;
        end
        c_in.dvalid = 1'b0;
        if (!acc) begin
            n_tests++; n_fail++;
            $display("FAIL send_c_timeout data=%0h not accepted within 50 cycles", d);
        end
    endtask

    task automatic drain_b(input bit bp);
        for (int k = 0; k < 400 && qb.size() < 64; k++) begin
            b_out.dready = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
            @(posedge clk);
            #1;
        end
        b_out.dready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (a_out.dvalid !== 1'b0) begin
            n_fail++; $display("FAIL reset_a_dvalid got=%b want=0", a_out.dvalid);
        end
        n_tests++;
        if (b_out.dvalid !== 1'b0) begin
            n_fail++; $display("FAIL reset_b_dvalid got=%b want=0", b_out.dvalid);
        end
        n_tests++;
        if (c_out.dvalid !== 1'b0) begin
            n_fail++; $display("FAIL reset_c_dvalid got=%b want=0", c_out.dvalid);
        end
        n_tests++;
        if (dut_a.cnt_r !== 2'd0) begin
            n_fail++; $display("FAIL reset_cnt got=%0d want=0", dut_a.cnt_r);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_chunking();
        logic [9:0]  e0;
        logic [9:0]  e1;
        logic [19:0] exp;
        e0 = 10'b10_1000_1000;
        e1 = 10'b10_0000_0000;
        qa.delete();
        for (int i = 0; i < 10; i++) send_a(17'(i), (i == 9));
        idle(3);
        n_tests++;
        if (qa.size() != 10) begin
            n_fail++; $display("FAIL basic_count got=%0d want=10", qa.size());
        end
        for (int i = 0; i < 10 && i < qa.size(); i++) begin
            exp = {e1[i], e1[i], e0[i], 17'(i)};
            n_tests++;
            if (qa[i] !== exp) begin
                n_fail++; $display("FAIL basic_elem%0d got=%h want=%h", i, qa[i], exp);
            end
        end
    endtask

    task automatic test_short_transactions();
        logic [6:0]  e0;
        logic [6:0]  e1;
        logic [19:0] exp;
        e0 = 7'b110_0010;
        e1 = 7'b100_0010;
        qa.delete();
        send_a(17'h20, 1'b0);
        send_a(17'h21, 1'b1);
        n_tests++;
        if (dut_a.cnt_r !== 2'd0) begin
            n_fail++; $display("FAIL short_cnt_restart got=%0d want=0", dut_a.cnt_r);
        end
        for (int i = 2; i < 7; i++) send_a(17'(32 + i), (i == 6));
        idle(3);
        n_tests++;
        if (qa.size() != 7) begin
            n_fail++; $display("FAIL short_count got=%0d want=7", qa.size());
        end
        for (int i = 0; i < 7 && i < qa.size(); i++) begin
            exp = {e1[i], e1[i], e0[i], 17'(32 + i)};
            n_tests++;
            if (qa[i] !== exp) begin
                n_fail++; $display("FAIL short_elem%0d got=%h want=%h", i, qa[i], exp);
            end
        end
    endtask

    task automatic test_backpressure();
        int          c;
        logic        e;
        logic        e0;
        logic [19:0] exp;
        qb.delete();
        for (int i = 0; i < 64; i++) send_b(17'(i * 37 + 5), (i == 20 || i == 41 || i == 63), 1'b0);
        drain_b(1'b0);
        ref_q = qb;
        qb.delete();
        b_unstable = 0;
        for (int i = 0; i < 64; i++) send_b(17'(i * 37 + 5), (i == 20 || i == 41 || i == 63), 1'b1);
        drain_b(1'b1);
        idle(2);
        n_tests++;
        if (ref_q.size() != 64) begin
            n_fail++; $display("FAIL bp_ref_count got=%0d want=64", ref_q.size());
        end
        n_tests++;
        if (qb.size() != 64) begin
            n_fail++; $display("FAIL bp_count got=%0d want=64", qb.size());
        end
        c = 0;
        for (int i = 0; i < 64 && i < ref_q.size() && i < qb.size(); i++) begin
            e = (i == 20 || i == 41 || i == 63);
            e0 = (c == 2) || e;
            c = e0 ? 0 : c + 1;
            exp = {e, e, e0, 17'(i * 37 + 5)};
            n_tests++;
            if (ref_q[i] !== exp) begin
                n_fail++; $display("FAIL bp_ref_elem%0d got=%h want=%h", i, ref_q[i], exp);
            end
            n_tests++;
            if (qb[i] !== exp) begin
                n_fail++; $display("FAIL bp_elem%0d got=%h want=%h", i, qb[i], exp);
            end
        end
        n_tests++;
        if (b_unstable != 0) begin
            n_fail++; $display("FAIL bp_stable got=%0d changes want=0", b_unstable);
        end
    endtask

    task automatic test_size1_flat();
        logic [18:0] exp;
        qc.delete();
        for (int i = 0; i < 5; i++) send_c(17'(10 + i));
        idle(3);
        n_tests++;
        if (qc.size() != 5) begin
            n_fail++; $display("FAIL size1_count got=%0d want=5", qc.size());
        end
        for (int i = 0; i < 5 && i < qc.size(); i++) begin
            exp = {1'b0, 1'b1, 17'(10 + i)};
            n_tests++;
            if (qc[i] !== exp) begin
                n_fail++; $display("FAIL size1_elem%0d got=%h want=%h", i, qc[i], exp);
            end
        end
    endtask

    task automatic test_reset_mid_chunk();
        logic [19:0] exp;
        send_a(17'h100, 1'b0);
        send_a(17'h101, 1'b0);
        a_out.dready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        qa.delete();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_tests++;
            if (a_out.dvalid !== 1'b0) begin
                n_fail++; $display("FAIL rst_mid_dvalid%0d got=%b want=0", k, a_out.dvalid);
            end
            @(posedge clk);
            #1;
        end
        a_out.dready = 1'b1;
        for (int i = 0; i < 4; i++) send_a(17'(336 + i), 1'b0);
        idle(3);
        n_tests++;
        if (qa.size() != 4) begin
            n_fail++; $display("FAIL rst_mid_count got=%0d want=4", qa.size());
        end
        for (int i = 0; i < 4 && i < qa.size(); i++) begin
            exp = {1'b0, 1'b0, (i == 3), 17'(336 + i)};
            n_tests++;
            if (qa[i] !== exp) begin
                n_fail++; $display("FAIL rst_mid_elem%0d got=%h want=%h", i, qa[i], exp);
            end
        end
    endtask

    task automatic test_throughput();
        int xfers;
        xfers = 0;
        a_out.dready = 1'b1;
        a_in.eot = 1'b0;
        a_in.dvalid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            a_in.data = 18'(k);
            @(negedge clk);
            if (a_out.dvalid && a_out.dready) xfers++;
            @(posedge clk);
            #1;
        end
        a_in.dvalid = 1'b0;
        idle(3);
        n_tests++;
        if (xfers != EXP_TP) begin
            n_fail++; $display("FAIL throughput got=%0d want=%0d", xfers, EXP_TP);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        rst = 1'b1;
        a_in.data = '0; a_in.dvalid = 1'b0; a_in.eot = 1'b0; a_out.dready = 1'b1;
        b_in.data = '0; b_in.dvalid = 1'b0; b_in.eot = 1'b0; b_out.dready = 1'b1;
        c_in.data = '0; c_in.dvalid = 1'b0; c_in.eot = 1'b0; c_out.dready = 1'b1;
        #1;
        test_reset();
        test_basic_chunking();
        test_short_transactions();
        test_backpressure();
        test_size1_flat();
        test_reset_mid_chunk();
        test_throughput();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
